// File: rtl/ultrasonic_echo_ranger_pkg.sv
// rtl/ultrasonic_echo_ranger_pkg.sv - shared state encoding, timing defaults and widths for the echo ranger
package ultrasonic_echo_ranger_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        HOLDOFF   = 3'd4
    } state_t;

    // Default timing for a 100 MHz system clock and an HC-SR04-class sensor
    localparam int DEF_TICK_DIV   = 100;
    localparam int DEF_TRIG_US    = 10;
    localparam int DEF_TIMEOUT_US = 30000;
    localparam int DEF_MAX_US     = 38000;
    localparam int DEF_HOLDOFF_US = 60000;
    localparam int DEF_US_PER_CM  = 58;

    // Result widths and the per-state microsecond counter width
    localparam int US_W     = 16;
    localparam int CM_W     = 10;
    localparam int US_CNT_W = 17;

endpackage

// File: rtl/ultrasonic_echo_ranger_us_tick_gen.sv
// rtl/ultrasonic_echo_ranger_us_tick_gen.sv - clearable prescaler producing a one-cycle tick every microsecond
module us_tick_gen #(
    parameter int TICK_DIV = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    // Count 0..TICK_DIV-1; a clear realigns so the first tick lands TICK_DIV cycles later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ultrasonic_echo_ranger.sv
// rtl/ultrasonic_echo_ranger.sv - trigger, echo timing and range conversion engine
module ultrasonic_echo_ranger
    import ultrasonic_echo_ranger_pkg::*;
#(
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int TRIG_US    = DEF_TRIG_US,
    parameter int TIMEOUT_US = DEF_TIMEOUT_US,
    parameter int MAX_US     = DEF_MAX_US,
    parameter int HOLDOFF_US = DEF_HOLDOFF_US,
    parameter int US_PER_CM  = DEF_US_PER_CM
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            echo,
    output logic            trigger,
    output logic            busy,
    output logic            done,
    output logic            timeout,
    output logic [US_W-1:0] echo_us,
    output logic [CM_W-1:0] distance_cm
);

    localparam int SUB_W = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;

    localparam logic [US_CNT_W-1:0] TRIG_LAST    = US_CNT_W'(TRIG_US - 1);
    localparam logic [US_CNT_W-1:0] TIMEOUT_LAST = US_CNT_W'(TIMEOUT_US - 1);
    localparam logic [US_CNT_W-1:0] HOLD_LAST    = US_CNT_W'(HOLDOFF_US - 1);
    localparam logic [US_W-1:0]     MAX_LAST     = US_W'(MAX_US - 1);
    localparam logic [US_W-1:0]     MAX_VAL      = US_W'(MAX_US);
    localparam logic [SUB_W-1:0]    SUB_LAST     = SUB_W'(US_PER_CM - 1);

    state_t state;
    state_t state_next;

    logic echo_m;
    logic echo_s;
    logic echo_d;

    logic tick;
    logic state_change;

    logic [US_CNT_W-1:0] us_cnt;
    logic [US_W-1:0]     w;
    logic [SUB_W-1:0]    sub;
    logic [CM_W-1:0]     cm;
    logic [CM_W-1:0]     cm_inc;

    logic rise;
    logic trig_end;
    logic wait_expired;
    logic meas_fall;
    logic meas_full;
    logic hold_end;

    logic            trigger_d;
    logic            done_d;
    logic            timeout_d;
    logic [US_W-1:0] echo_us_d;
    logic [CM_W-1:0] distance_cm_d;

    assign state_change = (state_next != state);
    assign busy         = (state != IDLE);

    us_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (state_change),
        .tick  (tick)
    );

    // Reaching a microsecond limit means the tick that completes the last microsecond
    assign trig_end     = tick && (us_cnt == TRIG_LAST);
    assign wait_expired = tick && (us_cnt == TIMEOUT_LAST);
    assign hold_end     = tick && (us_cnt == HOLD_LAST);
    assign meas_full    = tick && (w == MAX_LAST);
    assign rise         = echo_s && !echo_d;
    // MEASURE starts one cycle after echo_s rises, so the end is judged on the
    // delayed sample; that keeps the counted window equal to the echo high time
    assign meas_fall    = !echo_d;
    assign cm_inc       = (sub == SUB_LAST) ? cm + CM_W'(1) : cm;

    // Two-flop synchroniser for the asynchronous echo plus one delay flop for edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_m <= 1'b0;
            echo_s <= 1'b0;
            echo_d <= 1'b0;
        end else begin
            echo_m <= echo;
            echo_s <= echo_m;
            echo_d <= echo_s;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection; start outside IDLE is simply not looked at
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (start) state_next = TRIG;
            TRIG:      if (trig_end) state_next = WAIT_RISE;
            WAIT_RISE: begin
                if (rise) begin
                    state_next = MEASURE;
                end else if (wait_expired) begin
                    state_next = HOLDOFF;
                end
            end
            MEASURE:   if (meas_fall || meas_full) state_next = HOLDOFF;
            HOLDOFF:   if (hold_end) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Output decode: next values of the registered outputs, results updated only with done
    always_comb begin
        trigger_d     = (state_next == TRIG);
        done_d        = 1'b0;
        timeout_d     = timeout;
        echo_us_d     = echo_us;
        distance_cm_d = distance_cm;
        case (state)
            WAIT_RISE: begin
                if (!rise && wait_expired) begin
                    timeout_d     = 1'b1;
                    done_d        = 1'b1;
                    echo_us_d     = '0;
                    distance_cm_d = '0;
                end
            end
            MEASURE: begin
                if (meas_fall) begin
                    timeout_d     = 1'b0;
                    done_d        = 1'b1;
                    echo_us_d     = w;
                    distance_cm_d = cm;
                end else if (meas_full) begin
                    timeout_d     = 1'b1;
                    done_d        = 1'b1;
                    echo_us_d     = MAX_VAL;
                    distance_cm_d = cm_inc;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs so trigger and done are glitch-free
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trigger     <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            echo_us     <= '0;
            distance_cm <= '0;
        end else begin
            trigger     <= trigger_d;
            done        <= done_d;
            timeout     <= timeout_d;
            echo_us     <= echo_us_d;
            distance_cm <= distance_cm_d;
        end
    end

    // Per-state microsecond counter, restarted on every state change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            us_cnt <= '0;
        end else if (state_change) begin
            us_cnt <= '0;
        end else if (tick && (state != IDLE)) begin
            us_cnt <= us_cnt + 1'b1;
        end
    end

    // Echo width and centimetre accumulation, zeroed whenever MEASURE is not active
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w   <= '0;
            sub <= '0;
            cm  <= '0;
        end else if (state != MEASURE) begin
            w   <= '0;
            sub <= '0;
            cm  <= '0;
        end else if (tick) begin
            w   <= w + 1'b1;
            sub <= (sub == SUB_LAST) ? '0 : sub + 1'b1;
            cm  <= cm_inc;
        end
    end

endmodule

// File: tb/tb_ultrasonic_echo_ranger.sv
// tb/tb_ultrasonic_echo_ranger.sv - self-checking bench for ultrasonic_echo_ranger
module tb_ultrasonic_echo_ranger;

    localparam int TD   = 4;
    localparam int TRG  = 10;
    localparam int TMO  = 100;
    localparam int MAXU = 400;
    localparam int HOLD = 50;
    localparam int UPC  = 58;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic        echo  = 1'b0;
    logic        trigger;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] echo_us;
    logic [9:0]  distance_cm;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ultrasonic_echo_ranger #(
        .TICK_DIV   (TD),
        .TRIG_US    (TRG),
        .TIMEOUT_US (TMO),
        .MAX_US     (MAXU),
        .HOLDOFF_US (HOLD),
        .US_PER_CM  (UPC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .echo        (echo),
        .trigger     (trigger),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .echo_us     (echo_us),
        .distance_cm (distance_cm)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired at %0t", what, $time);
    endtask

    // Model: phases 0 idle, 1 trigger, 2 wait rise, 3 measure, 4 holdoff.
    // Time is tracked as raw clock cycles spent in the phase; microseconds are cycles / TD.
    int   m_phase = 0;
    int   m_n     = 0;
    int   m_us    = 0;
    int   m_cm    = 0;
    bit   m_to    = 1'b0;
    bit   m_done  = 1'b0;
    bit   h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;

    always @(posedge clk or posedge rst) begin : model
        int nxt;
        if (rst) begin
            m_phase = 0; m_n = 0; m_us = 0; m_cm = 0;
            m_to = 1'b0; m_done = 1'b0;
            h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
        end else begin
            m_done = 1'b0;
            nxt    = m_phase;
            case (m_phase)
                0: if (start) nxt = 1;
                1: if (m_n == TRG * TD - 1) nxt = 2;
                2: begin
                    if (h2 && !h3) begin
                        nxt = 3;
                    end else if (m_n == TMO * TD - 1) begin
                        nxt = 4; m_done = 1'b1; m_to = 1'b1; m_us = 0; m_cm = 0;
                    end
                end
                3: begin
                    if (!h3) begin
                        nxt = 4; m_done = 1'b1; m_to = 1'b0;
                        m_us = m_n / TD; m_cm = m_us / UPC;
                    end else if (m_n == MAXU * TD - 1) begin
                        nxt = 4; m_done = 1'b1; m_to = 1'b1;
                        m_us = MAXU; m_cm = MAXU / UPC;
                    end
                end
                4: if (m_n == HOLD * TD - 1) nxt = 0;
                default: nxt = 0;
            endcase
            m_n     = (nxt != m_phase) ? 0 : m_n + 1;
            m_phase = nxt;
            h3 = h2; h2 = h1; h1 = echo;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("trigger", int'(trigger), int'(m_phase == 1));
            chk("busy", int'(busy), int'(m_phase != 0));
            chk("done", int'(done), int'(m_done));
            chk("timeout", int'(timeout), int'(m_to));
            chk("echo_us", int'(echo_us), m_us);
            chk("distance_cm", int'(distance_cm), m_cm);
        end
    end

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic trig_cycle(output int width);
        int g;
        g = 0;
        width = 0;
        while (trigger !== 1'b1 && g < 100) begin @(negedge clk); g++; end
        if (g >= 100) bound_fail("trigger_rise");
        while (trigger === 1'b1 && width < 1000) begin @(negedge clk); width++; end
    endtask

    task automatic wait_done(output int c);
        c = 0;
        while (done !== 1'b1 && c < 5000) begin @(negedge clk); c++; end
        if (c >= 5000) bound_fail("done_wait");
    endtask

    task automatic wait_idle(output int c);
        c = 0;
        while (busy === 1'b1 && c < 5000) begin @(negedge clk); c++; end
        if (c >= 5000) bound_fail("idle_wait");
    endtask

    task automatic expect_result(input string tag, input int us, input int cm, input int to);
        chk({tag, "_echo_us"}, int'(echo_us), us);
        chk({tag, "_distance_cm"}, int'(distance_cm), cm);
        chk({tag, "_timeout"}, int'(timeout), to);
    endtask

    initial begin
        int w;
        int c;
        int th;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_trigger", int'(trigger), 0);
        chk("reset_done", int'(done), 0);
        expect_result("reset", 0, 0, 0);

        // Trigger width, then no echo at all
        pulse_start();
        trig_cycle(w);
        chk("trig_width", w, 40);
        wait_done(c);
        chk("noecho_latency", c, 400);
        expect_result("noecho", 0, 0, 1);
        @(negedge clk);
        chk("done_one_cycle", int'(done), 0);
        wait_idle(c);

        // Normal 116 us echo
        pulse_start();
        trig_cycle(w);
        repeat (20) @(negedge clk);
        echo = 1'b1;
        repeat (464) @(negedge clk);
        echo = 1'b0;
        wait_done(c);
        expect_result("normal", 116, 2, 0);
        wait_idle(c);
        chk("holdoff_len", c, 200);

        // Echo stuck high beyond MAX_US
        pulse_start();
        trig_cycle(w);
        repeat (10) @(negedge clk);
        echo = 1'b1;
        wait_done(c);
        expect_result("stuck", 400, 6, 1);
        wait_idle(c);
        echo = 1'b0;
        repeat (5) @(negedge clk);

        // Echo already high when waiting begins; only the second pulse counts
        pulse_start();
        repeat (10) @(negedge clk);
        echo = 1'b1;
        trig_cycle(w);
        repeat (8) @(negedge clk);
        echo = 1'b0;
        repeat (10) @(negedge clk);
        echo = 1'b1;
        repeat (232) @(negedge clk);
        echo = 1'b0;
        wait_done(c);
        expect_result("second_pulse", 58, 1, 0);
        wait_idle(c);

        // Reset in the middle of MEASURE
        pulse_start();
        trig_cycle(w);
        repeat (5) @(negedge clk);
        echo = 1'b1;
        repeat (100) @(negedge clk);
        chk("pre_reset_busy", int'(busy), 1);
        rst  = 1'b1;
        echo = 1'b0;
        #1;
        chk("rst_meas_trigger", int'(trigger), 0);
        chk("rst_meas_busy", int'(busy), 0);
        chk("rst_meas_done", int'(done), 0);
        expect_result("rst_meas", 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset while the trigger is high drops it at once
        pulse_start();
        repeat (5) @(negedge clk);
        chk("pre_reset_trigger", int'(trigger), 1);
        rst = 1'b1;
        #1;
        chk("rst_trig_trigger", int'(trigger), 0);
        chk("rst_trig_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Clean cycle after reset
        pulse_start();
        trig_cycle(w);
        chk("post_reset_trig_width", w, 40);
        repeat (20) @(negedge clk);
        echo = 1'b1;
        repeat (232) @(negedge clk);
        echo = 1'b0;
        wait_done(c);
        expect_result("post_reset", 58, 1, 0);

        // Start during HOLDOFF is dropped
        repeat (10) @(negedge clk);
        pulse_start();
        th = 0;
        repeat (250) begin
            @(negedge clk);
            if (trigger === 1'b1) th++;
        end
        chk("holdoff_start_dropped", th, 0);
        chk("idle_after_holdoff", int'(busy), 0);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
